regfile_dump_reader: RTL and testbench

- Debug/readout engine that walks a contiguous range of register-file entries through a spare combinational read port.
- Streams each entry's address and value out on a valid/ready interface.
- Sits beside the register file. It is the read-side counterpart of the writeback path and feeds the debug/trace output or a test harness.
- Does not write the register file.

---
 rtl/regfile_dump_reader_if.sv | 30 +++
 rtl/regfile_dump_reader.sv | 126 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// Bus bundle between the dump reader, the register-file read port and the consumer.
// The master modport is the reader side; slave is the register file plus consumer side.
interface regfile_dump_reader_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic         START;
  logic [D-1:0] FIRST;
  logic [D:0]   COUNT;
  logic         ABORT;
  logic [D-1:0] RD_ADDR;
  logic [W-1:0] RD_DATA;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [D-1:0] OUT_ADDR;
  logic [W-1:0] OUT_DATA;
  logic         OUT_LAST;
  logic         BUSY;
  logic         DONE;

  modport master (
    input  START, FIRST, COUNT, ABORT, RD_DATA, OUT_READY,
    output RD_ADDR, OUT_VALID, OUT_ADDR, OUT_DATA, OUT_LAST, BUSY, DONE
  );

  modport slave (
    output START, FIRST, COUNT, ABORT, RD_DATA, OUT_READY,
    input  RD_ADDR, OUT_VALID, OUT_ADDR, OUT_DATA, OUT_LAST, BUSY, DONE
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a contiguous, wrapping range of register-file entries through a spare
// combinational read port and streams (address, value) beats over valid/ready.
module regfile_dump_reader #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  regfile_dump_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

  localparam logic [D:0] REM_ONE = {{D{1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [D-1:0] idx_q, idx_d;
  logic [D:0]   rem_q, rem_d;
  logic [D-1:0] rd_hold_q, rd_hold_d;
  logic [D-1:0] out_addr_q, out_addr_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic         xfer;
  logic         fetch;

  assign xfer = out_valid_q && bus.OUT_READY;

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    rd_hold_d   = rd_hold_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    fetch       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (bus.COUNT != '0) begin
            idx_d   = bus.FIRST;
            rem_d   = bus.COUNT;
            state_d = RUN;
          end else begin
            state_d = FIN;
          end
        end
      end

      RUN: begin
        rd_hold_d = idx_q;
        if (bus.ABORT) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end else begin
          if (xfer) out_valid_d = 1'b0;
          // A free or draining output slot lets the current entry be captured this cycle.
          fetch = !out_valid_q || bus.OUT_READY;
          if (fetch) begin
            out_data_d  = bus.RD_DATA;
            out_addr_d  = idx_q;
            out_valid_d = 1'b1;
            out_last_d  = (rem_q == REM_ONE);
            idx_d       = idx_q + 1'b1;
            if (rem_q != '0) rem_d = rem_q - 1'b1;
            if (rem_q == REM_ONE) state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (bus.ABORT) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end else if (xfer && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = FIN;
        end
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      rd_hold_q   <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      rd_hold_q   <= rd_hold_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // The read port follows idx while running and parks on the last address otherwise.
  assign bus.RD_ADDR   = (state_q == RUN) ? idx_q : rd_hold_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_ADDR  = out_addr_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_LAST  = out_last_q;
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.DONE      = (state_q == FIN);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a register-file array model feeds the
// read port, and every dump is compared against an expected beat list built from the range.
module tb_regfile_dump_reader;
  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 1 << D;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  regfile_dump_reader_if #(.W(W), .D(D)) bus ();
  regfile_dump_reader #(.W(W), .D(D)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  logic [W-1:0] regs [N];
  assign bus.RD_DATA = regs[bus.RD_ADDR];

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int addr;
    int data;
    int last;
  } beat_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  // abort_after > 0 pulses ABORT while the beat after that many transfers is presented.
  task automatic run_dump(input int first, input int count, input int ready_mode,
                          input int abort_after, input bit hold_start);
    beat_t        expq[$];
    beat_t        gotq[$];
    beat_t        b;
    int           c, last_c, first_c, xfers;
    bit           stall, done_seen;
    logic         rdy;
    logic [D-1:0] a;
    logic [D-1:0] s_addr;
    logic [W-1:0] s_data;
    logic         s_last;

    for (int k = 0; k < count; k++) begin
      a      = D'((first + k) % N);
      b.addr = int'(a);
      b.data = int'(regs[a]);
      b.last = int'(k == count - 1);
      expq.push_back(b);
    end

    bus.FIRST     = D'(first);
    bus.COUNT     = (D + 1)'(count);
    bus.START     = 1'b1;
    bus.OUT_READY = 1'b0;
    tick();
    if (!hold_start) bus.START = 1'b0;
    check("busy_after_start", 32'(bus.BUSY), 32'd1);

    c = 0; last_c = -1; first_c = -1; xfers = 0;
    stall = 1'b0; done_seen = 1'b0;
    s_addr = '0; s_data = '0; s_last = 1'b0;
    while (c < 300) begin
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.OUT_READY = rdy;
      #1;
      if (stall) begin
        check("stall_valid", 32'(bus.OUT_VALID), 32'd1);
        check("stall_addr",  32'(bus.OUT_ADDR),  32'(s_addr));
        check("stall_data",  32'(bus.OUT_DATA),  32'(s_data));
        check("stall_last",  32'(bus.OUT_LAST),  32'(s_last));
      end
      if (bus.DONE) begin
        done_seen = 1'b1;
        check("done_after_last_xfer", c, last_c + 1);
        bus.START = 1'b0;
        break;
      end
      if (bus.OUT_VALID && first_c < 0) first_c = c;
      if (abort_after > 0 && xfers == abort_after) begin
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        bus.START = 1'b0;
        check("abort_valid", 32'(bus.OUT_VALID), 32'd0);
        check("abort_busy",  32'(bus.BUSY),      32'd0);
        check("abort_done",  32'(bus.DONE),      32'd0);
        for (int k = 0; k < gotq.size(); k++) begin
          check("abort_beat_addr", gotq[k].addr, expq[k].addr);
          check("abort_beat_data", gotq[k].data, expq[k].data);
        end
        tick();
        check("abort_stays_idle", 32'(bus.BUSY), 32'd0);
        return;
      end
      if (bus.OUT_VALID && rdy) begin
        b.addr = int'(bus.OUT_ADDR);
        b.data = int'(bus.OUT_DATA);
        b.last = int'(bus.OUT_LAST);
        gotq.push_back(b);
        last_c = c;
        xfers++;
      end
      stall  = bus.OUT_VALID && !rdy;
      s_addr = bus.OUT_ADDR;
      s_data = bus.OUT_DATA;
      s_last = bus.OUT_LAST;
      tick();
      c++;
    end

    bus.START = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    check("first_valid_cycle", first_c, (count > 0) ? 1 : -1);
    check("beat_count", gotq.size(), expq.size());
    for (int k = 0; k < gotq.size() && k < expq.size(); k++) begin
      check("beat_addr", gotq[k].addr, expq[k].addr);
      check("beat_data", gotq[k].data, expq[k].data);
      check("beat_last", gotq[k].last, expq[k].last);
    end
    tick();
    check("idle_after_done_busy",  32'(bus.BUSY),      32'd0);
    check("idle_after_done_pulse", 32'(bus.DONE),      32'd0);
    check("idle_after_done_valid", 32'(bus.OUT_VALID), 32'd0);
  endtask

  initial begin
    bus.START = 1'b0;
    bus.FIRST = '0;
    bus.COUNT = '0;
    bus.ABORT = 1'b0;
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < N; i++) regs[i] = W'(8'h10 + i);

    #12;
    check("rst_valid",   32'(bus.OUT_VALID), 32'd0);
    check("rst_last",    32'(bus.OUT_LAST),  32'd0);
    check("rst_busy",    32'(bus.BUSY),      32'd0);
    check("rst_done",    32'(bus.DONE),      32'd0);
    check("rst_addr",    32'(bus.OUT_ADDR),  32'd0);
    check("rst_data",    32'(bus.OUT_DATA),  32'd0);
    check("rst_rd_addr", 32'(bus.RD_ADDR),   32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    check("idle_after_release", 32'(bus.BUSY), 32'd0);

    run_dump(0, 8, 0, 0, 1'b0);   // full dump, always ready
    run_dump(0, 8, 1, 0, 1'b0);   // backpressure 1,0,0
    run_dump(6, 4, 0, 0, 1'b0);   // wrap-around
    run_dump(0, 0, 0, 0, 1'b1);   // zero count, START held through FIN
    run_dump(0, 8, 0, 3, 1'b0);   // abort after third transfer
    run_dump(0, 8, 0, 0, 1'b0);   // clean restart after abort
    run_dump(3, 5, 2, 0, 1'b1);   // START held during RUN is ignored

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) regs[i] = W'($urandom);
      run_dump(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N)), 2, 0, 1'b0);
    end

    // Asynchronous reset dropped between clock edges in the middle of a dump.
    bus.FIRST = '0;
    bus.COUNT = (D + 1)'(N);
    bus.OUT_READY = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    check("pre_reset_valid", 32'(bus.OUT_VALID), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("async_rst_valid",   32'(bus.OUT_VALID), 32'd0);
    check("async_rst_busy",    32'(bus.BUSY),      32'd0);
    check("async_rst_done",    32'(bus.DONE),      32'd0);
    check("async_rst_rd_addr", 32'(bus.RD_ADDR),   32'd0);
    check("async_rst_addr",    32'(bus.OUT_ADDR),  32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle_busy",  32'(bus.BUSY),      32'd0);
      check("post_rst_idle_valid", 32'(bus.OUT_VALID), 32'd0);
    end

    for (int i = 0; i < N; i++) regs[i] = W'($urandom);
    run_dump(5, 8, 2, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
